// File: rtl/miv_rv32ima_l1_ahb_ram_ecc_scrub_if.sv
// Port bundle for the SECDED-protected simple-dual-port RAM.
// The master drives the write/read ports; the slave returns corrected data, flags and counters.
interface miv_rv32ima_l1_ahb_ram_ecc_scrub_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] WADDR;
  logic              WEN;
  logic [ADDR_W-1:0] RADDR;
  logic              REN;
  logic [DATA_W-1:0] RD;
  logic              RD_VALID;
  logic              SB_CORRECT;
  logic              DB_DETECT;
  logic [CNT_W-1:0]  SB_COUNT;
  logic [CNT_W-1:0]  DB_COUNT;

  modport master (
    output WD, WADDR, WEN, RADDR, REN,
    input  RD, RD_VALID, SB_CORRECT, DB_DETECT,
    input  SB_COUNT, DB_COUNT
  );

  modport slave (
    input  WD, WADDR, WEN, RADDR, REN,
    output RD, RD_VALID, SB_CORRECT, DB_DETECT,
    output SB_COUNT, DB_COUNT
  );
endinterface

// File: rtl/miv_rv32ima_l1_ahb_ram_ecc_scrub.sv
// SECDED simple-dual-port RAM with demand-correction write-back and error counters.
// Optional background scrubber enabled by defining MIV_RAM_ECC_SCRUB_EN.
module miv_rv32ima_l1_ahb_ram_ecc_scrub #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = 11,
  parameter int CNT_W          = 16,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic CLK,
  input  logic RST,
  miv_rv32ima_l1_ahb_ram_ecc_scrub_if.slave bus
);

  function automatic int calc_p(int dw);
    int p = 2;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int P     = calc_p(DATA_W);
  localparam int ECC_W = P + 1;
  localparam int CW    = DATA_W + ECC_W;

  // Hamming position of data bit i (skips power-of-two check slots)
  function automatic logic [P-1:0] hpos(int i);
    logic [P-1:0] r = '0;
    int k = 0;
    for (int p = 3; p < (1 << P); p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == i) r = P'(p);
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [P-1:0] chk_bits(logic [DATA_W-1:0] d);
    logic [P-1:0] c = '0;
    for (int i = 0; i < DATA_W; i++)
      if (d[i]) c ^= hpos(i);
    return c;
  endfunction

  // Codeword layout: {overall parity, check bits, data}
  function automatic logic [CW-1:0] enc(logic [DATA_W-1:0] d);
    logic [P-1:0] c;
    c = chk_bits(d);
    return {^{c, d}, c, d};
  endfunction

  logic [CW-1:0]     mem [0:DEPTH-1];

  logic [ADDR_W-1:0] rd_addr;
  logic [CW-1:0]     rd_cw;
  logic [DATA_W-1:0] raw_data;
  logic [DATA_W-1:0] fix_data;
  logic [P-1:0]      syn;
  logic              par;
  logic              dec_sb;
  logic              dec_db;
  logic              scrub_go;
  logic              rd_act;
  logic              sb_ev;
  logic              db_ev;

  logic [DATA_W-1:0] rd_q;
  logic              vld_q;
  logic              sbf_q;
  logic              dbf_q;
  logic [CNT_W-1:0]  sbc_q;
  logic [CNT_W-1:0]  dbc_q;

  logic              wb_pending;
  logic [ADDR_W-1:0] wb_addr;
  logic [CW-1:0]     wb_cw;
  logic              wb_do;
  logic              wb_hit;
  logic              wb_load;

  always_comb begin
    rd_cw    = mem[rd_addr];
    raw_data = rd_cw[DATA_W-1:0];
    syn      = rd_cw[DATA_W +: P] ^ chk_bits(raw_data);
    par      = ^rd_cw;
    dec_sb   = par;
    dec_db   = !par && (syn != '0);
    fix_data = raw_data;
    for (int i = 0; i < DATA_W; i++)
      if (par && (syn == hpos(i))) fix_data[i] = ~raw_data[i];
  end

  assign rd_act  = bus.REN || scrub_go;
  assign sb_ev   = rd_act && dec_sb;
  assign db_ev   = rd_act && dec_db;
  assign wb_do   = wb_pending && !bus.WEN;
  assign wb_hit  = bus.WEN && (bus.WADDR == wb_addr);
  // A user write to the address being corrected supersedes the correction
  assign wb_load = sb_ev && !(bus.WEN && (bus.WADDR == rd_addr));

  always_ff @(posedge CLK) begin
    if (bus.WEN)
      mem[bus.WADDR] <= enc(bus.WD);
    else if (wb_do && !RST)
      mem[wb_addr] <= wb_cw;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q       <= '0;
      vld_q      <= 1'b0;
      sbf_q      <= 1'b0;
      dbf_q      <= 1'b0;
      sbc_q      <= '0;
      dbc_q      <= '0;
      wb_pending <= 1'b0;
      wb_addr    <= '0;
      wb_cw      <= '0;
    end else begin
      vld_q <= bus.REN;
      sbf_q <= bus.REN && dec_sb;
      dbf_q <= bus.REN && dec_db;
      if (bus.REN) rd_q <= fix_data;
      if (sb_ev && (sbc_q != '1)) sbc_q <= sbc_q + 1'b1;
      if (db_ev && (dbc_q != '1)) dbc_q <= dbc_q + 1'b1;
      if (wb_pending) begin
        if (wb_do || wb_hit) wb_pending <= 1'b0;
      end else if (wb_load) begin
        wb_pending <= 1'b1;
        wb_addr    <= rd_addr;
        wb_cw      <= enc(fix_data);
      end
    end
  end

`ifdef MIV_RAM_ECC_SCRUB_EN
  localparam int TW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef enum logic {S_COUNT, S_REQ} scrub_st_e;

  scrub_st_e         st_q, st_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= S_COUNT;
      tmr_q   <= '0;
      saddr_q <= '0;
    end else begin
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      saddr_q <= saddr_d;
    end
  end

  // Demand reads and pending write-backs always take the port first
  always_comb begin
    st_d     = st_q;
    tmr_d    = tmr_q;
    saddr_d  = saddr_q;
    scrub_go = 1'b0;
    unique case (st_q)
      S_COUNT: begin
        if (tmr_q == TW'(SCRUB_INTERVAL - 1)) begin
          st_d  = S_REQ;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_REQ: begin
        if (!bus.REN && !wb_pending) begin
          scrub_go = 1'b1;
          st_d     = S_COUNT;
          tmr_d    = '0;
          saddr_d  = saddr_q + 1'b1;
        end
      end
      default: st_d = S_COUNT;
    endcase
  end

  assign rd_addr = scrub_go ? saddr_q : bus.RADDR;
`else
  logic unused_cfg;
  assign unused_cfg = ^SCRUB_INTERVAL;
  assign scrub_go   = 1'b0;
  assign rd_addr    = bus.RADDR;
`endif

  assign bus.RD         = rd_q;
  assign bus.RD_VALID   = vld_q;
  assign bus.SB_CORRECT = sbf_q;
  assign bus.DB_DETECT  = dbf_q;
  assign bus.SB_COUNT   = sbc_q;
  assign bus.DB_COUNT   = dbc_q;

endmodule
